care_scheduler: RTL

Sequences all care actions onto the single shared action executor behind the companion interface. User-selected actions (feed, play, clean, heal) are buffered in a small FIFO. Periodic stat-decay events are generated from the watch tick. The block grants one action at a time over an exec/exec_status handshake, with a watchdog that aborts hung actions.

---
 rtl/care_pkg.sv | 26 ++
 rtl/action_fifo.sv | 63 ++++++
 rtl/care_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/care_pkg.sv
// Shared types and action codes for the care action scheduler.
package care_pkg;

    localparam logic [2:0] ACT_FEED  = 3'd0;
    localparam logic [2:0] ACT_PLAY  = 3'd1;
    localparam logic [2:0] ACT_CLEAN = 3'd2;
    localparam logic [2:0] ACT_HEAL  = 3'd3;
    localparam logic [2:0] ACT_DECAY = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } state_e;

    typedef enum logic {
        USER  = 1'b0,
        DECAY = 1'b1
    } src_e;

    // User actions occupy the lower half of the executor code space.
    function automatic logic [2:0] user_code(input logic [1:0] act);
        return {1'b0, act};
    endfunction

endpackage

// File: rtl/action_fifo.sv
// Small synchronous FIFO buffering 2-bit user action codes.
module action_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [1:0] data_i,
    input  logic       pop_i,
    output logic [1:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/care_scheduler.sv
// Arbitrates queued user actions and periodic decay onto one shared executor,
// with an exec/exec_status handshake and a watchdog on hung actions.
module care_scheduler
    import care_pkg::*;
#(
    parameter int DECAY_TICKS    = 12,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       user_valid_i,
    input  logic [1:0] user_action_i,
    output logic       user_ready_o,
    output logic       exec_o,
    output logic [2:0] exec_action_o,
    input  logic       exec_status_i,
    output logic       busy_o,
    output logic       timeout_err_o,
    output logic [7:0] drop_count_o
);

    state_e      state_q, state_d;
    src_e        last_grant_q, last_grant_d;
    logic [2:0]  exec_action_q, exec_action_d;
    logic        decay_pending_q, decay_pending_d;
    logic [7:0]  tick_cnt_q, tick_cnt_d;
    logic [7:0]  drop_q, drop_d;
    logic [15:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    logic        fifo_full, fifo_empty, fifo_push;
    logic [1:0]  fifo_head;
    logic        grant_user, grant_decay, decay_wrap;

    assign fifo_push = user_valid_i && user_ready_o;

    action_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (user_action_i),
        .pop_i   (grant_user),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        exec_action_d = exec_action_q;
        wd_d          = wd_q;
        timeout_d     = 1'b0;
        grant_user    = 1'b0;
        grant_decay   = 1'b0;
        case (state_q)
            IDLE: begin
                // A still-busy executor (status high) blocks new grants.
                if (!exec_status_i) begin
                    if (decay_pending_q && (fifo_empty || last_grant_q == USER)) begin
                        grant_decay = 1'b1;
                    end else if (!fifo_empty) begin
                        grant_user = 1'b1;
                    end
                end
                if (grant_decay) begin
                    exec_action_d = ACT_DECAY;
                    last_grant_d  = DECAY;
                end else if (grant_user) begin
                    exec_action_d = user_code(fifo_head);
                    last_grant_d  = USER;
                end
                if (grant_decay || grant_user) begin
                    state_d = ISSUE;
                    wd_d    = '0;
                end
            end
            ISSUE, RUN: begin
                wd_d = wd_q + 1'b1;
                if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else if (state_q == ISSUE && exec_status_i) begin
                    state_d = RUN;
                end else if (state_q == RUN && !exec_status_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new wrap outranks the grant clearing the old event on the same edge.
    always_comb begin
        decay_wrap      = tick_i && (tick_cnt_q == 8'(DECAY_TICKS - 1));
        tick_cnt_d      = tick_cnt_q;
        decay_pending_d = decay_pending_q;
        drop_d          = drop_q;
        if (tick_i) begin
            tick_cnt_d = decay_wrap ? 8'd0 : tick_cnt_q + 8'd1;
        end
        if (decay_wrap) begin
            decay_pending_d = 1'b1;
            if (decay_pending_q && !grant_decay && drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (grant_decay) begin
            decay_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            last_grant_q    <= USER;
            exec_action_q   <= '0;
            decay_pending_q <= 1'b0;
            tick_cnt_q      <= '0;
            drop_q          <= '0;
            wd_q            <= '0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            exec_action_q   <= exec_action_d;
            decay_pending_q <= decay_pending_d;
            tick_cnt_q      <= tick_cnt_d;
            drop_q          <= drop_d;
            wd_q            <= wd_d;
            timeout_q       <= timeout_d;
        end
    end

    assign user_ready_o  = !fifo_full;
    assign exec_o        = (state_q == ISSUE);
    assign busy_o        = (state_q != IDLE);
    assign exec_action_o = exec_action_q;
    assign timeout_err_o = timeout_q;
    assign drop_count_o  = drop_q;

endmodule
